bp_initiator: RTL and testbench
===============================

Name: bp_initiator

Overview:
- BytePipe initiator: turns register-access requests into BytePipe command/data bytes, and collects the responder's reply bytes.
- Sits on the host/test side of a BytePipe link. Drives the same byte protocol our correlator register responder consumes (over USB or direct loopback in sim).
- Handles single writes, single reads and burst reads; a burst read sets up the responder's burst register at address 0 first.

Parameters:
- BURST_ADDR, 0, responder address of burst-length register.
- (No others; widths fixed by protocol: 8b bytes, 7b address.)

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  synchronous reset, active-low.
- i_cg  in  1  clock-gate enable; all state holds when 0.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid&&ready.
- i_req_wr  in  1  1=write, 0=read.
- i_req_addr  in  7  register address.
- i_req_wrdata  in  8  write data (writes only).
- i_req_len  in  8  read length minus one (0 → 1 byte, 255 → 256); ignored for writes.
- o_bp_data  out  8  byte to responder.
- o_bp_valid  out  1  byte valid.
- i_bp_ready  in  1  responder accepts byte.
- i_bp_data  in  8  byte from responder.
- i_bp_valid  in  1  responder byte valid.
- o_bp_ready  out  1  initiator accepts byte.
- o_rsp_data  out  8  response byte to user.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  user accepts response.
- o_rsp_last  out  1  final byte of a request's response.
- o_busy  out  1  transaction in progress (state != IDLE).

Behaviour:
- Reset (i_rstn=0 at posedge with i_cg=1):
  - state=IDLE; o_bp_valid=0, o_bp_data=0.
  - o_req_ready=1; o_rsp_valid=0; o_busy=0.
  - Count register=0.
- Command byte = {wr, addr[6:0]}.
- Request acceptance:
  - Accepted only in IDLE; o_req_ready = (state==IDLE).
  - Fields latched on acceptance.
  - If addr==BURST_ADDR, the effective read length is forced to 0 (responder never bursts at addr 0).
- FSM (registered o_bp_data/o_bp_valid):
  - IDLE: on accept → write: CMD; read with len==0: CMD; read with len!=0: BSCMD.
  - BSCMD: present 0x80|BURST_ADDR; on i_bp_ready → BSLEN.
  - BSLEN: present len; on i_bp_ready → BSRSP.
  - BSRSP: o_bp_ready=1; one byte discarded (not on rsp channel); on i_bp_valid → CMD.
  - CMD: present command byte; on i_bp_ready → WRDATA (write) or RSP (read).
  - WRDATA: present wrdata; on i_bp_ready → RSP, with count=0.
  - RSP: forward count+1 bytes, then → IDLE.
- Latency: o_bp_valid rises the cycle after request acceptance. Each byte is held stable until i_bp_ready; the next byte is presented the cycle after acceptance, so there are no bubbles when ready is held high.
- Response forwarding (combinational pass-through):
  - In RSP: o_rsp_data=i_bp_data; o_rsp_valid=i_bp_valid; o_bp_ready=i_rsp_ready.
  - o_rsp_last=(count==0) in RSP.
  - Count decrements on each i_bp_valid&&i_rsp_ready; at 0 → IDLE.
- Outside RSP/BSRSP: o_bp_ready=0, o_rsp_valid=0, o_rsp_last=0.
- Write response: exactly one byte (the register value the responder returns), forwarded with last=1.
- Read length L=len+1 yields exactly L response bytes, all forwarded.
- o_bp_valid is never dropped while a byte is unaccepted.
- Reset mid-transaction: immediate return to IDLE, all valids low. Responder resynchronisation is the system's responsibility; document, do not handle.
- i_cg=0: no state change. Combinational outputs still track inputs, but state does not advance.

Decomposition:
- Shared package bp_pkg:
  - CMD_WR_BIT=7, BP_ADDR_W=7, BURST_ADDR=0.
  - FSM state enum {IDLE,BSCMD,BSLEN,BSRSP,CMD,WRDATA,RSP}.
  - Same constants reused by the responder side.
- No sub-module; a single FSM plus an 8b downcounter.

Test Plan:
- Single write addr 6, data 0x05, ready high → o_bp bytes 0x86 then 0x05 on consecutive cycles. Responder reply 0x00 → one rsp beat 0x00 with last=1; busy drops the cycle after.
- Single read addr 2, len 0 → byte 0x02. Reply 0x14 → rsp 0x14 with last=1.
- Burst read addr 1, len 3 → bytes 0x80, 0x03. First reply discarded (no rsp_valid), then byte 0x01. Replies A,B,C,D → 4 rsp beats, last only on D.
- Backpressure: random i_bp_ready and i_rsp_ready during a burst read.
  - o_bp_data stable while valid&&!ready.
  - o_bp_ready tracks i_rsp_ready in RSP.
  - No bytes lost or duplicated.
- Read addr 0 with len 5 → no burst setup; single byte 0x00 sent, one rsp beat with last=1.
- Assert i_rstn=0 while in RSP of a len 7 read.
  - Next cycle: IDLE, o_bp_valid=0, o_rsp_valid=0, o_req_ready=1.
  - A new single read then completes normally.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - BytePipe protocol constants and FSM state type shared by initiator and responder
package bp_pkg;

  localparam int CMD_WR_BIT = 7;
  localparam int BP_ADDR_W  = 7;
  localparam int BP_DATA_W  = 8;
  localparam logic [BP_ADDR_W-1:0] BURST_ADDR = 7'd0;

  typedef enum logic [2:0] {
    IDLE,
    BSCMD,
    BSLEN,
    BSRSP,
    CMD,
    WRDATA,
    RSP
  } bp_state_e;

  function automatic logic [BP_DATA_W-1:0] bp_cmd_byte(input logic wr,
                                                       input logic [BP_ADDR_W-1:0] addr);
    logic [BP_DATA_W-1:0] b;
    b             = {1'b0, addr};
    b[CMD_WR_BIT] = wr;
    return b;
  endfunction

endpackage

// File: rtl/bp_initiator.sv
// rtl/bp_initiator.sv - BytePipe initiator: register requests to command bytes, replies to response beats
// After a reset mid-transaction the responder may be left mid-command; resynchronising it is up to the system.
module bp_initiator
  import bp_pkg::*;
#(
  parameter logic [BP_ADDR_W-1:0] BURST_ADDR = bp_pkg::BURST_ADDR
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_cg,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_wr,
  input  logic [BP_ADDR_W-1:0] i_req_addr,
  input  logic [BP_DATA_W-1:0] i_req_wrdata,
  input  logic [BP_DATA_W-1:0] i_req_len,
  output logic [BP_DATA_W-1:0] o_bp_data,
  output logic                 o_bp_valid,
  input  logic                 i_bp_ready,
  input  logic [BP_DATA_W-1:0] i_bp_data,
  input  logic                 i_bp_valid,
  output logic                 o_bp_ready,
  output logic [BP_DATA_W-1:0] o_rsp_data,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic                 o_rsp_last,
  output logic                 o_busy
);

  bp_state_e              state_q, state_d;
  logic [BP_DATA_W-1:0]   bp_data_q, bp_data_d;
  logic                   bp_valid_q, bp_valid_d;
  logic                   wr_q, wr_d;
  logic [BP_ADDR_W-1:0]   addr_q, addr_d;
  logic [BP_DATA_W-1:0]   wrdata_q, wrdata_d;
  logic [BP_DATA_W-1:0]   len_q, len_d;
  logic [BP_DATA_W-1:0]   count_q, count_d;
  logic [BP_DATA_W-1:0]   eff_len;

  // The responder never bursts at the burst register itself, so such reads collapse to one byte.
  assign eff_len = (i_req_addr == BURST_ADDR) ? '0 : i_req_len;

  always_comb begin
    state_d    = state_q;
    bp_data_d  = bp_data_q;
    bp_valid_d = bp_valid_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wrdata_d   = wrdata_q;
    len_d      = len_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          wr_d       = i_req_wr;
          addr_d     = i_req_addr;
          wrdata_d   = i_req_wrdata;
          len_d      = eff_len;
          bp_valid_d = 1'b1;
          if (!i_req_wr && eff_len != '0) begin
            state_d   = BSCMD;
            bp_data_d = bp_cmd_byte(1'b1, BURST_ADDR);
          end else begin
            state_d   = CMD;
            bp_data_d = bp_cmd_byte(i_req_wr, i_req_addr);
          end
        end
      end
      BSCMD: begin
        if (i_bp_ready) begin
          state_d   = BSLEN;
          bp_data_d = len_q;
        end
      end
      BSLEN: begin
        if (i_bp_ready) begin
          state_d    = BSRSP;
          bp_valid_d = 1'b0;
          bp_data_d  = '0;
        end
      end
      BSRSP: begin
        if (i_bp_valid) begin
          state_d    = CMD;
          bp_valid_d = 1'b1;
          bp_data_d  = bp_cmd_byte(wr_q, addr_q);
        end
      end
      CMD: begin
        if (i_bp_ready) begin
          if (wr_q) begin
            state_d   = WRDATA;
            bp_data_d = wrdata_q;
          end else begin
            state_d    = RSP;
            bp_valid_d = 1'b0;
            bp_data_d  = '0;
            count_d    = len_q;
          end
        end
      end
      WRDATA: begin
        if (i_bp_ready) begin
          state_d    = RSP;
          bp_valid_d = 1'b0;
          bp_data_d  = '0;
          count_d    = '0;
        end
      end
      RSP: begin
        if (i_bp_valid && i_rsp_ready) begin
          if (count_q == '0) state_d = IDLE;
          else               count_d = count_q - 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        bp_valid_d = 1'b0;
        bp_data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_cg) begin
      if (!i_rstn) begin
        state_q    <= IDLE;
        bp_data_q  <= '0;
        bp_valid_q <= 1'b0;
        wr_q       <= 1'b0;
        addr_q     <= '0;
        wrdata_q   <= '0;
        len_q      <= '0;
        count_q    <= '0;
      end else begin
        state_q    <= state_d;
        bp_data_q  <= bp_data_d;
        bp_valid_q <= bp_valid_d;
        wr_q       <= wr_d;
        addr_q     <= addr_d;
        wrdata_q   <= wrdata_d;
        len_q      <= len_d;
        count_q    <= count_d;
      end
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);
  assign o_bp_data   = bp_data_q;
  assign o_bp_valid  = bp_valid_q;
  assign o_bp_ready  = (state_q == RSP) ? i_rsp_ready : (state_q == BSRSP);
  assign o_rsp_valid = (state_q == RSP) && i_bp_valid;
  assign o_rsp_data  = (state_q == RSP) ? i_bp_data : '0;
  assign o_rsp_last  = (state_q == RSP) && (count_q == '0);

endmodule

// File: tb/tb_bp_initiator.sv
// tb/tb_bp_initiator.sv - table-driven scoreboard bench for bp_initiator with a gated responder model
module tb_bp_initiator;

  logic       clk = 1'b0;
  logic       i_rstn, i_cg, i_req_valid, i_req_wr;
  logic [6:0] i_req_addr;
  logic [7:0] i_req_wrdata, i_req_len;
  logic       i_bp_ready, i_bp_valid, i_rsp_ready;
  logic [7:0] i_bp_data;
  logic       o_req_ready, o_bp_valid, o_bp_ready, o_rsp_valid, o_rsp_last, o_busy;
  logic [7:0] o_bp_data, o_rsp_data;

  always #5 clk = ~clk;

  bp_initiator dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_cg(i_cg),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
    .i_req_addr(i_req_addr), .i_req_wrdata(i_req_wrdata), .i_req_len(i_req_len),
    .o_bp_data(o_bp_data), .o_bp_valid(o_bp_valid), .i_bp_ready(i_bp_ready),
    .i_bp_data(i_bp_data), .i_bp_valid(i_bp_valid), .o_bp_ready(o_bp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_last(o_rsp_last), .o_busy(o_busy)
  );

  typedef struct {
    logic            wr;
    logic [6:0]      addr;
    logic [7:0]      wrdata;
    logic [7:0]      len;
    int              ntx;
    logic [2:0][7:0] tx;
    int              nrsp;
    bit              burst;
    logic [7:0]      rbase;
    bit              rnd;
    int              cg_gap;
  } vec_t;

  vec_t       vecs[8];
  vec_t       cur;
  int         n_chk = 0, n_pass = 0;
  int         cyc = 0, tx_acc = 0, rsp_seen = 0, last_tx_cyc = 0, cg_left = 0;
  bit         req_pending = 0, rnd = 0, just_acc = 0, expect_idle = 0, prev_hold = 0;
  logic [7:0] prev_data;
  logic [7:0] exp_tx_q[$];
  logic [8:0] exp_rsp_q[$];
  logic [7:0] rep_data[$];
  int         rep_need[$];

  function automatic vec_t mk(logic wr, logic [6:0] addr, logic [7:0] wrdata, logic [7:0] len,
                              int ntx, logic [7:0] t0, logic [7:0] t1, logic [7:0] t2, int nrsp,
                              bit burst, logic [7:0] rbase, bit r, int cg_gap);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wrdata = wrdata; v.len = len; v.ntx = ntx;
    v.tx[0] = t0; v.tx[1] = t1; v.tx[2] = t2; v.nrsp = nrsp; v.burst = burst;
    v.rbase = rbase; v.rnd = r; v.cg_gap = cg_gap;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(string name);
    n_chk++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  task automatic on_accept();
    req_pending = 0; just_acc = 1; tx_acc = 0; rsp_seen = 0; cg_left = cur.cg_gap;
    for (int i = 0; i < cur.ntx; i++) exp_tx_q.push_back(cur.tx[i]);
    if (cur.burst) begin
      rep_data.push_back(8'hEE); rep_need.push_back(2);
    end
    for (int k = 0; k < cur.nrsp; k++) begin
      exp_rsp_q.push_back({k == cur.nrsp - 1, 8'(int'(cur.rbase) + k)});
      rep_data.push_back(8'(int'(cur.rbase) + k)); rep_need.push_back(cur.ntx);
    end
  endtask

  task automatic step();
    logic [8:0] e;
    logic [7:0] t;
    @(negedge clk);
    cyc++;
    i_cg = (cg_left > 0) ? 1'b0 : 1'b1;
    if (cg_left > 0) cg_left--;
    i_req_valid = req_pending; i_req_wr = cur.wr; i_req_addr = cur.addr;
    i_req_wrdata = cur.wrdata; i_req_len = cur.len;
    i_bp_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    i_rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rep_data.size() > 0 && tx_acc >= rep_need[0]) begin
      i_bp_valid = 1'b1; i_bp_data = rep_data[0];
    end else begin
      i_bp_valid = 1'b0; i_bp_data = 8'h00;
    end
    #1;
    if (just_acc) begin chk("valid_after_accept", int'(o_bp_valid), 1); just_acc = 0; end
    if (prev_hold) begin
      chk("hold_valid", int'(o_bp_valid), 1);
      chk("hold_data", int'(o_bp_data), int'(prev_data));
    end
    if (expect_idle) begin
      chk("busy_drop", int'(o_busy), 0);
      chk("req_ready_idle", int'(o_req_ready), 1);
      expect_idle = 0;
    end
    if (o_rsp_valid) chk("bp_ready_tracks_rsp_ready", int'(o_bp_ready), int'(i_rsp_ready));
    if (i_cg) begin
      if (i_req_valid && o_req_ready) on_accept();
      else if (o_bp_valid && i_bp_ready) begin
        if (exp_tx_q.size() == 0) fail_now("tx_extra");
        else begin
          t = exp_tx_q.pop_front();
          chk("tx_byte", int'(o_bp_data), int'(t));
        end
        if (!rnd && cur.cg_gap == 0 && tx_acc > 0 && !(cur.burst && tx_acc == 2))
          chk("tx_no_bubble", cyc, last_tx_cyc + 1);
        last_tx_cyc = cyc;
        tx_acc++;
      end
      if (i_bp_valid && o_bp_ready) begin
        void'(rep_data.pop_front()); void'(rep_need.pop_front());
      end
      if (o_rsp_valid && i_rsp_ready) begin
        if (exp_rsp_q.size() == 0) fail_now("rsp_extra");
        else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_data", int'(o_rsp_data), int'(e[7:0]));
          chk("rsp_last", int'(o_rsp_last), int'(e[8]));
          rsp_seen++;
          if (e[8]) expect_idle = 1;
        end
      end
    end else begin
      chk("cg_busy_hold", int'(o_busy), 1);
    end
    prev_hold = o_bp_valid && !(i_bp_ready && i_cg);
    prev_data = o_bp_data;
  endtask

  task automatic run_vec(vec_t v, int stop_rsp);
    cur = v; rnd = v.rnd; req_pending = 1;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (stop_rsp >= 0 && !req_pending && rsp_seen >= stop_rsp) return;
      if (!req_pending && exp_tx_q.size() == 0 && exp_rsp_q.size() == 0 &&
          rep_data.size() == 0 && !expect_idle) return;
    end
    fail_now("timeout");
    req_pending = 0; exp_tx_q.delete(); exp_rsp_q.delete(); rep_data.delete(); rep_need.delete();
  endtask

  initial begin
    vecs[0] = mk(1'b1, 7'h06, 8'h05, 8'h00, 2, 8'h86, 8'h05, 8'h00,   1, 0, 8'h00, 0, 0);
    vecs[1] = mk(1'b0, 7'h02, 8'h00, 8'h00, 1, 8'h02, 8'h00, 8'h00,   1, 0, 8'h14, 0, 0);
    vecs[2] = mk(1'b0, 7'h01, 8'h00, 8'h03, 3, 8'h80, 8'h03, 8'h01,   4, 1, 8'hA0, 0, 0);
    vecs[3] = mk(1'b0, 7'h2A, 8'h00, 8'h09, 3, 8'h80, 8'h09, 8'h2A,  10, 1, 8'h40, 1, 0);
    vecs[4] = mk(1'b0, 7'h00, 8'h00, 8'h05, 1, 8'h00, 8'h00, 8'h00,   1, 0, 8'h77, 0, 0);
    vecs[5] = mk(1'b1, 7'h7F, 8'hA5, 8'h00, 2, 8'hFF, 8'hA5, 8'h00,   1, 0, 8'h5A, 0, 3);
    vecs[6] = mk(1'b0, 7'h55, 8'h00, 8'hFF, 3, 8'h80, 8'hFF, 8'h55, 256, 1, 8'hC0, 0, 0);
    vecs[7] = mk(1'b0, 7'h10, 8'h00, 8'h01, 3, 8'h80, 8'h01, 8'h10,   2, 1, 8'h90, 1, 0);

    i_rstn = 1'b0; i_cg = 1'b1; i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_addr = '0;
    i_req_wrdata = '0; i_req_len = '0; i_bp_ready = 1'b0; i_bp_valid = 1'b0;
    i_bp_data = '0; i_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_bp_valid", int'(o_bp_valid), 0);
    chk("reset_bp_data", int'(o_bp_data), 0);
    chk("reset_req_ready", int'(o_req_ready), 1);
    chk("reset_rsp_valid", int'(o_rsp_valid), 0);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_rsp_last", int'(o_rsp_last), 0);
    i_rstn = 1'b1;

    for (int v = 0; v < 8; v++) run_vec(vecs[v], -1);

    // Reset while forwarding a multi-byte read, then prove a fresh read still works.
    run_vec(mk(1'b0, 7'h03, 8'h00, 8'h07, 3, 8'h80, 8'h07, 8'h03, 8, 1, 8'h20, 0, 0), 2);
    exp_tx_q.delete(); exp_rsp_q.delete(); rep_data.delete(); rep_need.delete();
    prev_hold = 0; just_acc = 0; expect_idle = 0;
    chk("pre_reset_busy", int'(o_busy), 1);
    i_rstn = 1'b0;
    step();
    @(negedge clk);
    i_rstn = 1'b1;
    #1;
    chk("midrst_bp_valid", int'(o_bp_valid), 0);
    chk("midrst_rsp_valid", int'(o_rsp_valid), 0);
    chk("midrst_req_ready", int'(o_req_ready), 1);
    chk("midrst_busy", int'(o_busy), 0);
    run_vec(mk(1'b0, 7'h04, 8'h00, 8'h00, 1, 8'h04, 8'h00, 8'h00, 1, 0, 8'h3C, 0, 0), -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
